// File: rtl/fetch_unit.sv
// fetch_unit: owns the program counter and runs a single-outstanding
// req/ack instruction fetch for the two-phase RV32I core.
module fetch_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            InstructionRead,
  input  logic            PCWrite,
  input  logic            Branch,
  input  logic            Zero,
  input  logic [XLEN-1:0] imm,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      opcode,
  output logic            instr_valid,
  output logic            fetch_stall,
  output logic            misalign
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_q, state_d;
  logic            issue;      // request launched at this edge
  logic            complete;   // response accepted at this edge
  logic [XLEN-1:0] offset;
  logic [XLEN-1:0] target;
  logic            target_ok;

  // Next-state and handshake decode.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    issue    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (InstructionRead) begin
          state_d = WAIT;
          issue   = 1'b1;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          state_d  = IDLE;
          complete = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // PC-update target; branch offsets have bit 0 forced to zero.
  always_comb begin
    offset    = (Branch & Zero) ? {imm[XLEN-1:1], 1'b0} : XLEN'(4);
    target    = pc + offset;
    target_ok = (target[1:0] == 2'b00);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Program counter and sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else if (PCWrite) begin
      if (target_ok) pc       <= target;
      else           misalign <= 1'b1;
    end
  end

  // Request address is captured from the pre-update pc when a fetch launches.
  always_ff @(posedge clk) begin
    if (rst)        imem_addr <= RESET_PC;
    else if (issue) imem_addr <= pc;
  end

  // Instruction register and its one-cycle load strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= complete;
      if (complete) instr <= imem_rdata;
    end
  end

  // Request and stall are both the registered WAIT state.
  assign imem_req    = (state_q == WAIT);
  assign fetch_stall = (state_q == WAIT);
  assign opcode      = instr[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed vectors, a zero-wait fetch sequence,
// and randomized traffic checked against a behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, InstructionRead, PCWrite, Branch, Zero, imem_ack;
  logic [31:0] imm, imem_rdata;
  logic        imem_req, instr_valid, fetch_stall, misalign;
  logic [31:0] imem_addr, pc, instr;
  logic [6:0]  opcode;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state.
  logic [31:0] m_pc, m_addr, m_instr;
  logic        m_busy, m_valid, m_mis;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .InstructionRead(InstructionRead), .PCWrite(PCWrite),
    .Branch(Branch), .Zero(Zero), .imm(imm), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .fetch_stall(fetch_stall), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ir, pw, br, z;
    logic [31:0] imm;
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] e_pc;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic        e_valid, e_mis;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model of one clock edge, applied to pre-edge model state.
  task automatic model_step(input logic r, ir, pw, br, z, input logic [31:0] im,
                            input logic ak, input logic [31:0] rd);
    logic [31:0] t;
    if (r) begin
      m_pc = RESET_PC; m_addr = RESET_PC; m_instr = NOP_INSTR;
      m_busy = 0; m_valid = 0; m_mis = 0;
    end else begin
      m_valid = m_busy && ak;
      if (m_busy) begin
        if (ak) begin m_instr = rd; m_busy = 0; end
      end else if (ir) begin
        m_busy = 1; m_addr = m_pc;
      end
      if (pw) begin
        t = m_pc + ((br && z) ? (im & ~32'd1) : 32'd4);
        if (t % 4 != 0) m_mis = 1;
        else            m_pc  = t;
      end
    end
  endtask

  // Drive one cycle from the falling edge, sample 1 time unit after the rising edge.
  task automatic cycle(input logic r, ir, pw, br, z, input logic [31:0] im,
                       input logic ak, input logic [31:0] rd);
    rst = r; InstructionRead = ir; PCWrite = pw; Branch = br; Zero = z;
    imm = im; imem_ack = ak; imem_rdata = rd;
    model_step(r, ir, pw, br, z, im, ak, rd);
    @(posedge clk); #1;
    check("pc",          pc,          m_pc);
    check("imem_req",    imem_req,    m_busy);
    check("fetch_stall", fetch_stall, m_busy);
    check("imem_addr",   imem_addr,   m_addr);
    check("instr",       instr,       m_instr);
    check("opcode",      opcode,      m_instr[6:0]);
    check("instr_valid", instr_valid, m_valid);
    check("misalign",    misalign,    m_mis);
    @(negedge clk);
  endtask

  initial begin
    rst = 1; InstructionRead = 0; PCWrite = 0; Branch = 0; Zero = 0;
    imm = '0; imem_ack = 0; imem_rdata = '0;
    m_pc = '0; m_addr = '0; m_instr = '0; m_busy = 0; m_valid = 0; m_mis = 0;

    //            rst ir pw br z  imm           ack rdata          e_pc          req e_addr        e_instr       val mis
    vecs[0]  = '{1, 0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0013, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0013, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 32'h0,         1, 32'hDEAD_BEEF, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0013, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0000, 1, 32'h0000_0000, 32'h0000_0013, 0, 0};
    vecs[4]  = '{0, 1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0000, 1, 32'h0000_0000, 32'h0000_0013, 0, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0000, 1, 32'h0000_0000, 32'h0000_0013, 0, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0000, 1, 32'h0000_0000, 32'h0000_0013, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 32'h0,         1, 32'h0020_81B3, 32'h0000_0000, 0, 32'h0000_0000, 32'h0020_81B3, 1, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0000, 0, 32'h0000_0000, 32'h0020_81B3, 0, 0};
    vecs[9]  = '{0, 0, 1, 1, 1, 32'h100,       0, 32'h0,         32'h0000_0100, 0, 32'h0000_0000, 32'h0020_81B3, 0, 0};
    vecs[10] = '{0, 0, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0104, 0, 32'h0000_0000, 32'h0020_81B3, 0, 0};
    vecs[11] = '{0, 0, 1, 1, 1, 32'hFFFF_FFF8, 0, 32'h0,         32'h0000_00FC, 0, 32'h0000_0000, 32'h0020_81B3, 0, 0};
    vecs[12] = '{0, 0, 1, 1, 0, 32'hFFFF_FFF8, 0, 32'h0,         32'h0000_0100, 0, 32'h0000_0000, 32'h0020_81B3, 0, 0};
    vecs[13] = '{0, 0, 1, 1, 1, 32'h6,         0, 32'h0,         32'h0000_0100, 0, 32'h0000_0000, 32'h0020_81B3, 0, 1};
    vecs[14] = '{0, 0, 1, 1, 1, 32'h100,       0, 32'h0,         32'h0000_0200, 0, 32'h0000_0000, 32'h0020_81B3, 0, 1};
    vecs[15] = '{0, 1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0200, 1, 32'h0000_0200, 32'h0020_81B3, 0, 1};
    vecs[16] = '{0, 0, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0204, 1, 32'h0000_0200, 32'h0020_81B3, 0, 1};
    vecs[17] = '{0, 0, 0, 0, 0, 32'h0,         1, 32'h0000_0297, 32'h0000_0204, 0, 32'h0000_0200, 32'h0000_0297, 1, 1};
    vecs[18] = '{0, 1, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0208, 1, 32'h0000_0204, 32'h0000_0297, 0, 1};
    vecs[19] = '{1, 0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0013, 0, 0};
    vecs[20] = '{0, 0, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFFF, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0013, 0, 0};
    vecs[21] = '{0, 0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0013, 0, 0};
    vecs[22] = '{0, 0, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,         32'hFFFF_FFFC, 0, 32'h0000_0000, 32'h0000_0013, 0, 0};
    vecs[23] = '{0, 0, 1, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0013, 0, 0};

    @(negedge clk);

    // Directed table: model tracks alongside, constants give the required values.
    for (int i = 0; i < 24; i++) begin
      cycle(vecs[i].rst, vecs[i].ir, vecs[i].pw, vecs[i].br, vecs[i].z,
            vecs[i].imm, vecs[i].ack, vecs[i].rdata);
      check($sformatf("vec%0d.pc", i),     pc,          vecs[i].e_pc);
      check($sformatf("vec%0d.req", i),    imem_req,    vecs[i].e_req);
      check($sformatf("vec%0d.stall", i),  fetch_stall, vecs[i].e_req);
      check($sformatf("vec%0d.addr", i),   imem_addr,   vecs[i].e_addr);
      check($sformatf("vec%0d.instr", i),  instr,       vecs[i].e_instr);
      check($sformatf("vec%0d.opcode", i), opcode,      vecs[i].e_instr[6:0]);
      check($sformatf("vec%0d.valid", i),  instr_valid, vecs[i].e_valid);
      check($sformatf("vec%0d.mis", i),    misalign,    vecs[i].e_mis);
    end

    // Zero-wait fetch followed by the earliest back-to-back request.
    cycle(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    check("zw.req_rise", imem_req, 1'b1);
    cycle(0, 0, 0, 0, 0, 32'h0, 1, 32'h0010_0093);
    check("zw.instr", instr, 32'h0010_0093);
    check("zw.opcode", opcode, 7'b0010011);
    check("zw.req_fall", imem_req, 1'b0);
    cycle(0, 1, 0, 0, 0, 32'h0, 0, 32'h0);
    check("b2b.req", imem_req, 1'b1);
    check("b2b.valid_drop", instr_valid, 1'b0);
    cycle(0, 0, 0, 0, 0, 32'h0, 1, 32'h0000_0033);
    check("b2b.instr", instr, 32'h0000_0033);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic        r, ir, pw, br, z, ak;
      logic [31:0] im, rd;
      r  = ($urandom_range(0, 99) == 0);
      ir = ($urandom_range(0, 2) != 0);
      pw = ($urandom_range(0, 2) == 0);
      br = $urandom_range(0, 1);
      z  = $urandom_range(0, 1);
      ak = $urandom_range(0, 1);
      rd = $urandom;
      case ($urandom_range(0, 3))
        0:       im = $urandom;
        1:       im = 32'($urandom_range(0, 15)) - 32'd8;
        default: im = (32'($urandom_range(0, 127)) << 2) - 32'd256;
      endcase
      cycle(r, ir, pw, br, z, im, ak, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
